// File: rtl/svm_sv_classifier_if.sv
// Bundle of the support-vector stream, query, result and status signals
// between the classifier and its neighbours.
interface svm_sv_classifier_if #(
  parameter int N_SV  = 16,
  parameter int ACC_W = 32
);
  localparam int CW = $clog2(N_SV) + 1;

  logic             sv_valid;
  logic [8:0]       alpha_in;
  logic [8:0]       x_sv_in;
  logic [1:0]       y_sv_in;
  logic             trainer_done;
  logic             q_valid;
  logic [8:0]       x_q;
  logic             q_ready;
  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_class;
  logic [ACC_W-1:0] res_score;
  logic [CW-1:0]    sv_count;
  logic             locked;
  logic             overflow;

  modport master (
    output sv_valid, alpha_in, x_sv_in, y_sv_in, trainer_done,
           q_valid, x_q, res_ready,
    input  q_ready, res_valid, res_class, res_score, sv_count, locked, overflow
  );

  modport slave (
    input  sv_valid, alpha_in, x_sv_in, y_sv_in, trainer_done,
           q_valid, x_q, res_ready,
    output q_ready, res_valid, res_class, res_score, sv_count, locked, overflow
  );
endinterface

// File: rtl/svm_sv_classifier.sv
// Captures the trainer's support-vector stream, then scores queries with a
// linear kernel, one stored vector per cycle.
module svm_sv_classifier #(
  parameter int                      N_SV  = 16,
  parameter int                      ACC_W = 32,
  parameter logic signed [ACC_W-1:0] BIAS  = '0
) (
  input logic                clk,
  input logic                reset,
  svm_sv_classifier_if.slave bus
);
  localparam int CW = $clog2(N_SV) + 1;
  localparam int IW = $clog2(N_SV);

  typedef enum logic [1:0] {CAPTURE, IDLE, RUN, OUT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             locked_q, locked_d;
  logic             ovf_q, ovf_d;
  logic [8:0]       xq_q, xq_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic [8:0] alpha_mem [N_SV];
  logic [8:0] x_mem     [N_SV];
  logic [1:0] y_mem     [N_SV];

  logic             wr_en;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic [26:0]      term;
  logic [ACC_W-1:0] term_ext;

  assign wr_idx   = cnt_q[IW-1:0];
  assign rd_idx   = idx_q[IW-1:0];
  // Full 27-bit unsigned product; cast into the accumulator width (wraps if narrower).
  assign term     = 27'(alpha_mem[rd_idx]) * 27'(x_mem[rd_idx]) * 27'(xq_q);
  assign term_ext = ACC_W'(term);

  // Next-state, capture and accumulate logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    locked_d = locked_q;
    ovf_d    = ovf_q;
    xq_d     = xq_q;
    acc_d    = acc_q;
    wr_en    = 1'b0;
    case (state_q)
      CAPTURE: begin
        if (bus.sv_valid) begin
          if (cnt_q < CW'(N_SV)) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (bus.trainer_done) begin
          state_d  = IDLE;
          locked_d = 1'b1;
        end
      end
      IDLE: begin
        if (bus.q_valid) begin
          xq_d    = bus.x_q;
          acc_d   = BIAS;
          idx_d   = '0;
          state_d = (cnt_q != '0) ? RUN : OUT;
        end
      end
      RUN: begin
        case (y_mem[rd_idx])
          2'b01:   acc_d = acc_q + term_ext;
          2'b11:   acc_d = acc_q - term_ext;
          default: acc_d = acc_q;
        endcase
        idx_d = idx_q + 1'b1;
        if (idx_q == cnt_q - 1'b1) state_d = OUT;
      end
      OUT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = CAPTURE;
    endcase
  end

  // State and datapath registers; reset discards any result in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CAPTURE;
      cnt_q    <= '0;
      idx_q    <= '0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      xq_q     <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
      xq_q     <= xq_d;
      acc_q    <= acc_d;
    end
  end

  // Support-vector storage; contents beyond cnt_q are never read, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      alpha_mem[wr_idx] <= bus.alpha_in;
      x_mem[wr_idx]     <= bus.x_sv_in;
      y_mem[wr_idx]     <= bus.y_sv_in;
    end
  end

  // Outputs; result fields read zero outside OUT.
  always_comb begin
    bus.q_ready   = (state_q == IDLE);
    bus.res_valid = (state_q == OUT);
    bus.res_score = bus.res_valid ? acc_q : '0;
    bus.res_class = bus.res_valid ? (acc_q[ACC_W-1] ? 2'b11 : 2'b01) : 2'b00;
    bus.sv_count  = cnt_q;
    bus.locked    = locked_q;
    bus.overflow  = ovf_q;
  end
endmodule

// File: tb/tb_svm_sv_classifier.sv
// Directed plus randomized bench for svm_sv_classifier against a list-based
// score model.
module tb_svm_sv_classifier;
  localparam int N_SV  = 16;
  localparam int ACC_W = 32;
  localparam logic signed [ACC_W-1:0] BIAS = -7;

  logic clk;
  logic reset;
  svm_sv_classifier_if #(.N_SV(N_SV), .ACC_W(ACC_W)) bus ();

  svm_sv_classifier #(.N_SV(N_SV), .ACC_W(ACC_W), .BIAS(BIAS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int unsigned m_alpha[$];
  int unsigned m_x[$];
  int          m_y[$];
  bit          m_locked;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint model_score(input int unsigned xq);
    longint s;
    s = longint'(BIAS);
    foreach (m_alpha[i]) s += longint'(m_y[i]) * longint'(m_alpha[i]) * longint'(m_x[i]) * longint'(xq);
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.sv_valid = 0; bus.alpha_in = 0; bus.x_sv_in = 0; bus.y_sv_in = 0;
    bus.trainer_done = 0; bus.q_valid = 0; bus.x_q = 0; bus.res_ready = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_alpha.delete(); m_x.delete(); m_y.delete();
    m_locked = 0; m_ovf = 0;
    chk("rst_q_ready", bus.q_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_class", bus.res_class, 0);
    chk("rst_res_score", bus.res_score, 0);
    chk("rst_sv_count", bus.sv_count, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_overflow", bus.overflow, 0);
  endtask

  task automatic cap(input logic [8:0] a, input logic [8:0] x, input logic [1:0] y, input bit done);
    bus.sv_valid = 1; bus.alpha_in = a; bus.x_sv_in = x; bus.y_sv_in = y;
    bus.trainer_done = done;
    @(posedge clk); #1;
    bus.sv_valid = 0; bus.trainer_done = 0;
    if (!m_locked) begin
      if (m_alpha.size() < N_SV) begin
        m_alpha.push_back(a); m_x.push_back(x);
        m_y.push_back(y == 2'b01 ? 1 : (y == 2'b11 ? -1 : 0));
      end else m_ovf = 1;
      if (done) m_locked = 1;
    end
    chk("cap_sv_count", bus.sv_count, m_alpha.size());
    chk("cap_overflow", bus.overflow, m_ovf);
    if (done) chk("cap_done_locked", bus.locked, 1);
  endtask

  task automatic rand_cap(input bit done);
    logic [1:0] y;
    case ($urandom_range(0, 2))
      0: y = 2'b01;
      1: y = 2'b11;
      default: y = 2'b00;
    endcase
    cap(9'($urandom), 9'($urandom), y, done);
  endtask

  task automatic lock();
    bus.trainer_done = 1;
    @(posedge clk); #1;
    bus.trainer_done = 0;
    m_locked = 1;
    chk("lock_locked", bus.locked, 1);
    chk("lock_q_ready", bus.q_ready, 1);
  endtask

  // Accept a query, wait for the result, check latency and value, consume it.
  task automatic run_query(input logic [8:0] xq, input string tag);
    longint s;
    logic [31:0] e;
    int cyc;
    s = model_score(xq);
    e = s[31:0];
    bus.x_q = xq; bus.q_valid = 1;
    @(posedge clk); #1;
    bus.q_valid = 0;
    cyc = 1;
    while (!bus.res_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_latency"}, cyc, m_alpha.size() + 1);
    chk({tag, "_score"}, bus.res_score, e);
    chk({tag, "_class"}, bus.res_class, e[31] ? 2'b11 : 2'b01);
    chk({tag, "_q_ready_out"}, bus.q_ready, 0);
    bus.res_ready = 1;
    @(posedge clk); #1;
    bus.res_ready = 0;
    chk({tag, "_done_valid"}, bus.res_valid, 0);
    chk({tag, "_done_class"}, bus.res_class, 0);
    chk({tag, "_idle_q_ready"}, bus.q_ready, 1);
  endtask

  initial begin
    longint s;
    logic [31:0] e1, e2;
    logic [8:0] xq1, xq2;
    int cyc;

    do_reset();

    // basic scoring: -50 + BIAS
    cap(9'd3, 9'd10, 2'b01, 0);
    cap(9'd2, 9'd20, 2'b11, 0);
    lock();
    run_query(9'd5, "basic");
    run_query(9'd0, "zero_query");

    // score of exactly zero classifies as +1
    do_reset();
    cap(9'd7, 9'd1, 2'b01, 0);
    lock();
    run_query(9'd1, "zero_score");

    // empty store
    do_reset();
    lock();
    chk("empty_sv_count", bus.sv_count, 0);
    run_query(9'd9, "empty");

    // overflow, then capture after lock is ignored
    do_reset();
    for (int i = 0; i < 17; i++) rand_cap(0);
    chk("ovf_sticky", bus.overflow, 1);
    chk("ovf_count", bus.sv_count, 16);
    lock();
    rand_cap(0);
    run_query(9'($urandom), "ovf_query");

    // backpressure with a query held pending
    xq1 = 9'($urandom); xq2 = 9'($urandom);
    s = model_score(xq1); e1 = s[31:0];
    s = model_score(xq2); e2 = s[31:0];
    bus.x_q = xq1; bus.q_valid = 1;
    @(posedge clk); #1;
    bus.x_q = xq2;
    cyc = 1;
    while (!bus.res_valid && cyc < 100) begin
      chk("bp_run_q_ready", bus.q_ready, 0);
      @(posedge clk); #1; cyc++;
    end
    chk("bp_latency", cyc, N_SV + 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", bus.res_valid, 1);
      chk("bp_hold_score", bus.res_score, e1);
      chk("bp_hold_q_ready", bus.q_ready, 0);
      @(posedge clk); #1;
    end
    bus.res_ready = 1;
    @(posedge clk); #1;
    bus.res_ready = 0;
    chk("bp_after_hs_valid", bus.res_valid, 0);
    chk("bp_after_hs_q_ready", bus.q_ready, 1);
    @(posedge clk); #1;
    bus.q_valid = 0;
    chk("bp_accepted", bus.q_ready, 0);
    cyc = 1;
    while (!bus.res_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("bp2_latency", cyc, N_SV + 1);
    chk("bp2_score", bus.res_score, e2);
    bus.res_ready = 1;
    @(posedge clk); #1;
    bus.res_ready = 0;

    // reset in the middle of a run
    do_reset();
    for (int i = 0; i < 4; i++) rand_cap(0);
    lock();
    bus.x_q = 9'd100; bus.q_valid = 1;
    @(posedge clk); #1;
    bus.q_valid = 0;
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 5; i++) rand_cap(i == 4);
    run_query(9'($urandom), "post_reset");

    // randomized rounds, last triple sometimes paired with trainer_done
    for (int r = 0; r < 4; r++) begin
      int n;
      bit pair;
      do_reset();
      n = $urandom_range(1, N_SV);
      pair = 1'($urandom);
      for (int i = 0; i < n; i++) rand_cap(pair && (i == n - 1));
      if (!pair) lock();
      for (int q = 0; q < 4; q++) run_query(9'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
